// File: rtl/alu_multicycle_unit.sv
// Handshaked execute-stage ALU. Single-cycle ADD/SUB/CMP/logic/shift/MOV,
// iterative shift-add MUL (or single-cycle when FAST_MUL=1) and iterative
// restoring DIV/MOD. CMP flags are registered and held between compares.
module alu_multicycle_unit #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          FAST_MUL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [12:0]      op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       flags,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {IT_MUL, IT_DIV, IT_MOD} iter_t;

    state_t           r_state;
    state_t           w_state_nxt;
    iter_t            r_iter;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic [1:0]       r_flags;
    logic             r_dbz;

    // Iteration registers are shared by MUL and DIV/MOD:
    //   MUL: r_lo = accumulator, r_x = multiplicand (shifts left), r_y = multiplier (shifts right)
    //   DIV: r_lo = partial remainder, r_x = divisor, r_y = dividend shifting into quotient
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;

    logic [12:0]      w_op_sel;
    logic             w_iterative;
    logic             w_accept;
    logic             w_last_iter;
    logic [WIDTH-1:0] w_single;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_asr;
    logic             w_big_shamt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_x_nxt;
    logic [WIDTH-1:0] w_y_nxt;
    logic [WIDTH:0]   w_rem_sh;
    logic             w_rem_ge;

    // Lowest set bit of a multi-hot op wins; op==0 decodes to nothing (result 0).
    always_comb begin
        w_op_sel    = op & (~op + 13'd1);
        w_iterative = w_op_sel[4] | w_op_sel[5] | (w_op_sel[3] & !FAST_MUL);
        w_accept    = in_valid & in_ready & ~flush;
        w_last_iter = (r_cnt == CW'(WIDTH - 1));
    end

    // Single-cycle datapath, evaluated on the live operands at accept time.
    always_comb begin
        w_diff      = operand_a - operand_b;
        w_prod      = operand_a * operand_b;
        w_big_shamt = |operand_b[WIDTH-1:CW];
        w_asr       = $signed(operand_a) >>> operand_b[CW-1:0];
        w_single    = '0;
        case (1'b1)
            w_op_sel[0]:  w_single = operand_a + operand_b;
            w_op_sel[1]:  w_single = w_diff;
            w_op_sel[2]:  w_single = w_diff;
            w_op_sel[3]:  w_single = w_prod;
            w_op_sel[6]:  w_single = w_big_shamt ? '0 : (operand_a << operand_b[CW-1:0]);
            w_op_sel[7]:  w_single = w_big_shamt ? '0 : (operand_a >> operand_b[CW-1:0]);
            w_op_sel[8]:  w_single = w_big_shamt ? {WIDTH{operand_a[WIDTH-1]}} : w_asr;
            w_op_sel[9]:  w_single = operand_a | operand_b;
            w_op_sel[10]: w_single = operand_a & operand_b;
            w_op_sel[11]: w_single = ~operand_a;
            w_op_sel[12]: w_single = operand_b;
            default:      w_single = '0;
        endcase
    end

    // One step of shift-add multiply or restoring division.
    always_comb begin
        w_rem_sh = {r_lo, r_y[WIDTH-1]};
        w_rem_ge = (w_rem_sh >= {1'b0, r_x});
        if (r_iter == IT_MUL) begin
            w_lo_nxt = r_lo + (r_y[0] ? r_x : '0);
            w_x_nxt  = r_x << 1;
            w_y_nxt  = r_y >> 1;
        end else begin
            // The true remainder always fits WIDTH bits, so a WIDTH-bit subtract suffices.
            w_lo_nxt = w_rem_ge ? (w_rem_sh[WIDTH-1:0] - r_x) : w_rem_sh[WIDTH-1:0];
            w_x_nxt  = r_x;
            w_y_nxt  = {r_y[WIDTH-2:0], w_rem_ge};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; flush overrides everything, including a same-cycle accept.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid) w_state_nxt = w_iterative ? S_BUSY : S_DONE;
            S_BUSY: if (w_last_iter) w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = in_valid ? (w_iterative ? S_BUSY : S_DONE) : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
        out_valid = (r_state == S_DONE);
    end

    // Operand capture, iteration and result/flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= '0;
            r_dbz    <= 1'b0;
            r_cnt    <= '0;
            r_iter   <= IT_MUL;
            r_lo     <= '0;
            r_x      <= '0;
            r_y      <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            if (w_iterative) begin
                r_cnt <= '0;
                r_lo  <= '0;
                if (w_op_sel[3]) begin
                    r_iter <= IT_MUL;
                    r_x    <= operand_a;
                    r_y    <= operand_b;
                end else begin
                    r_iter <= w_op_sel[4] ? IT_DIV : IT_MOD;
                    r_x    <= operand_b;
                    r_y    <= operand_a;
                end
            end else begin
                r_result <= w_single;
                r_dbz    <= 1'b0;
                if (w_op_sel[2])
                    r_flags <= {~w_diff[WIDTH-1] & (|w_diff), ~(|w_diff)};
            end
        end else if (r_state == S_BUSY) begin
            r_lo  <= w_lo_nxt;
            r_x   <= w_x_nxt;
            r_y   <= w_y_nxt;
            r_cnt <= r_cnt + CW'(1);
            if (w_last_iter) begin
                r_cnt    <= '0;
                r_result <= (r_iter == IT_DIV) ? w_y_nxt : w_lo_nxt;
                r_dbz    <= (r_iter != IT_MUL) && (r_x == '0);
            end
        end
    end

    assign result      = r_result;
    assign flags       = r_flags;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_alu_multicycle_unit.sv
// Scoreboard bench for alu_multicycle_unit: stimulus pushes hand-computed
// expectations, a monitor pops and compares whenever a result is presented.
module tb_alu_multicycle_unit;

    localparam logic [12:0] ADD = 13'h0001, SUB = 13'h0002, CMP = 13'h0004, MUL = 13'h0008,
                            DIV = 13'h0010, MOD = 13'h0020, LSL = 13'h0040, LSR = 13'h0080,
                            ASR = 13'h0100, OR_ = 13'h0200, AND = 13'h0400, NOT = 13'h0800,
                            MOV = 13'h1000;

    typedef struct {
        int          dut;
        logic [12:0] op;
        logic [31:0] res;
        logic [1:0]  flg;
        logic        dbz;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [12:0] op        [2];
    logic [31:0] opa       [2];
    logic [31:0] opb       [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] result    [2];
    logic [1:0]  flags     [2];
    logic        dbz       [2];

    exp_t        sb[$];
    bit          head_seen;
    int          cyc;
    int          n_cmp;
    int          n_bad;
    logic [1:0]  m_flags;
    logic [31:0] m_last;

    alu_multicycle_unit #(.WIDTH(32), .FAST_MUL(1'b0)) u_dut (
        .clk(clk), .reset(reset), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op[0]), .operand_a(opa[0]), .operand_b(opb[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .result(result[0]), .flags(flags[0]), .div_by_zero(dbz[0])
    );

    alu_multicycle_unit #(.WIDTH(32), .FAST_MUL(1'b1)) u_fast (
        .clk(clk), .reset(reset), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op[1]), .operand_a(opa[1]), .operand_b(opb[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .result(result[1]), .flags(flags[1]), .div_by_zero(dbz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Monitor: latency on first presentation, value every cycle presented, pop on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                if (out_valid[k]) begin
                    if (sb.size() == 0 || sb[0].dut != k) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output dut%0d: got result %h, expected no output", k, result[k]);
                    end else begin
                        if (!head_seen) begin
                            n_cmp++;
                            if (cyc - sb[0].acc_cyc != sb[0].lat) begin
                                n_bad++;
                                $display("FAIL latency dut%0d op %h: got %0d cycles, expected %0d",
                                         k, sb[0].op, cyc - sb[0].acc_cyc, sb[0].lat);
                            end
                            head_seen = 1'b1;
                        end
                        n_cmp++;
                        if (result[k] !== sb[0].res || flags[k] !== sb[0].flg || dbz[k] !== sb[0].dbz) begin
                            n_bad++;
                            $display("FAIL result dut%0d op %h: got res %h flags %b dbz %b, expected res %h flags %b dbz %b",
                                     k, sb[0].op, result[k], flags[k], dbz[k], sb[0].res, sb[0].flg, sb[0].dbz);
                        end
                        if (out_ready[k]) begin
                            void'(sb.pop_front());
                            head_seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Offer one op at posedge+1, wait (bounded) for acceptance, push expectation.
    task automatic issue(input int k, input logic [12:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [1:0] ef, input logic ed, input int lat,
                         input bit must_now);
        exp_t e;
        int   w;
        in_valid[k] = 1'b1;
        op[k]       = o;
        opa[k]      = a;
        opb[k]      = b;
        w           = 0;
        @(negedge clk);
        while (!in_ready[k] && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (w >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout dut%0d op %h: got in_ready 0, expected 1", k, o);
            in_valid[k] = 1'b0;
            return;
        end
        if (must_now) chk("back_to_back_in_ready_wait", 32'(w), 32'd0);
        e.dut = k; e.op = o; e.res = er; e.flg = ef; e.dbz = ed; e.acc_cyc = cyc; e.lat = lat;
        sb.push_back(e);
        m_flags = ef;
        m_last  = er;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
            head_seen = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] saved;
        n_cmp = 0; n_bad = 0; head_seen = 1'b0; m_flags = 2'b00; m_last = '0;
        for (int k = 0; k < 2; k++) begin
            flush[k] = 1'b0; in_valid[k] = 1'b0; op[k] = '0; opa[k] = '0; opb[k] = '0; out_ready[k] = 1'b1;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready[0]), 32'd1);
        chk("reset_out_valid", 32'(out_valid[0]), 32'd0);
        chk("reset_result", result[0], 32'd0);
        chk("reset_flags", 32'(flags[0]), 32'd0);
        chk("reset_dbz", 32'(dbz[0]), 32'd0);
        chk("reset_fast_in_ready", 32'(in_ready[1]), 32'd1);
        @(posedge clk); #1;

        // Wrap-around add; flags untouched.
        issue(0, ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 2'b00, 1'b0, 1, 1'b0);
        drain();

        // Reset in the middle of a DIV clears flags set by an earlier CMP.
        issue(0, CMP, 32'd7, 32'd3, 32'd4, 2'b10, 1'b0, 1, 1'b0);
        drain();
        issue(0, DIV, 32'd100, 32'd7, 32'd14, 2'b10, 1'b0, 33, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1 reset = 1'b0;
        m_flags = 2'b00; m_last = '0;
        @(negedge clk);
        chk("rst_busy_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_busy_in_ready", 32'(in_ready[0]), 32'd1);
        chk("rst_busy_flags", 32'(flags[0]), 32'd0);
        chk("rst_busy_result", result[0], 32'd0);
        @(posedge clk); #1;

        // Back-to-back compares.
        issue(0, CMP, 32'd5, 32'd5, 32'd0, 2'b01, 1'b0, 1, 1'b0);
        issue(0, CMP, 32'd7, 32'd3, 32'd4, 2'b10, 1'b0, 1, 1'b1);
        issue(0, CMP, 32'd3, 32'd7, 32'hFFFFFFFC, 2'b00, 1'b0, 1, 1'b1);
        issue(0, CMP, 32'd9, 32'd2, 32'd7, 2'b10, 1'b0, 1, 1'b1);
        // Multi-hot SUB|CMP decodes as SUB; op==0 gives 0; neither touches flags.
        issue(0, SUB | CMP, 32'd3, 32'd5, 32'hFFFFFFFE, 2'b10, 1'b0, 1, 1'b1);
        issue(0, 13'h0000, 32'd3, 32'd5, 32'd0, 2'b10, 1'b0, 1, 1'b1);
        issue(0, OR_, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 2'b10, 1'b0, 1, 1'b1);
        issue(0, AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 2'b10, 1'b0, 1, 1'b1);
        issue(0, NOT, 32'h12345678, 32'd0, 32'hEDCBA987, 2'b10, 1'b0, 1, 1'b1);
        issue(0, MOV, 32'd1, 32'hCAFEBABE, 32'hCAFEBABE, 2'b10, 1'b0, 1, 1'b1);
        // Shifts.
        issue(0, ASR, 32'h80000000, 32'd4, 32'hF8000000, 2'b10, 1'b0, 1, 1'b1);
        issue(0, ASR, 32'h80000000, 32'd40, 32'hFFFFFFFF, 2'b10, 1'b0, 1, 1'b1);
        issue(0, ASR, 32'h70000000, 32'd40, 32'h00000000, 2'b10, 1'b0, 1, 1'b1);
        issue(0, LSR, 32'hFFFFFFFF, 32'd32, 32'h00000000, 2'b10, 1'b0, 1, 1'b1);
        issue(0, LSR, 32'h80000000, 32'd31, 32'h00000001, 2'b10, 1'b0, 1, 1'b1);
        issue(0, LSL, 32'h00000001, 32'd31, 32'h80000000, 2'b10, 1'b0, 1, 1'b1);
        issue(0, LSL, 32'h00000001, 32'd32, 32'h00000000, 2'b10, 1'b0, 1, 1'b1);
        drain();

        // Iterative divide / modulo, including divide by zero.
        issue(0, DIV, 32'd100, 32'd7, 32'd14, 2'b10, 1'b0, 33, 1'b0);
        issue(0, MOD, 32'd100, 32'd7, 32'd2, 2'b10, 1'b0, 33, 1'b0);
        issue(0, DIV, 32'd9, 32'd0, 32'hFFFFFFFF, 2'b10, 1'b1, 33, 1'b0);
        issue(0, MOD, 32'd9, 32'd0, 32'd9, 2'b10, 1'b1, 33, 1'b0);
        issue(0, ADD, 32'd1, 32'd2, 32'd3, 2'b10, 1'b0, 1, 1'b0);
        issue(0, DIV, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 2'b10, 1'b0, 33, 1'b0);
        issue(0, MOD, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 2'b10, 1'b0, 33, 1'b0);
        // Iterative multiply.
        issue(0, MUL, 32'h10000, 32'h10000, 32'd0, 2'b10, 1'b0, 33, 1'b0);
        issue(0, MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 2'b10, 1'b0, 33, 1'b0);
        issue(0, MUL, 32'h1234, 32'h10, 32'h12340, 2'b10, 1'b0, 33, 1'b0);
        drain();

        // Single-cycle multiply instance (flags stay at reset value there).
        issue(1, MUL, 32'h10000, 32'h10000, 32'd0, 2'b00, 1'b0, 1, 1'b0);
        issue(1, MUL, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 2'b00, 1'b0, 1, 1'b1);
        issue(1, MUL, 32'h1234, 32'h10, 32'h12340, 2'b00, 1'b0, 1, 1'b1);
        drain();
        m_flags = 2'b10; m_last = 32'h12340;

        // Consumer stall: result held, in_ready low.
        out_ready[0] = 1'b0;
        issue(0, ADD, 32'd2, 32'd3, 32'd5, 2'b10, 1'b0, 1, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        drain();

        // Flush at BUSY cycle 10 of a DIV: nothing comes out, state unchanged.
        saved = m_last;
        issue(0, DIV, 32'd100, 32'd7, 32'd14, 2'b10, 1'b0, 33, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush[0] = 1'b1;
        void'(sb.pop_back());
        m_last = saved;
        @(posedge clk);
        #1 flush[0] = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid[0]), 32'd0);
        chk("flush_in_ready", 32'(in_ready[0]), 32'd1);
        chk("flush_flags", 32'(flags[0]), 32'(m_flags));
        chk("flush_result", result[0], m_last);
        repeat (40) @(posedge clk);
        #1;

        // Flush together with an offered op: the op is dropped.
        in_valid[0] = 1'b1; op[0] = ADD; opa[0] = 32'd1; opb[0] = 32'd1; flush[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0; flush[0] = 1'b0;
        @(negedge clk);
        chk("flush_accept_out_valid", 32'(out_valid[0]), 32'd0);
        chk("flush_accept_result", result[0], m_last);
        @(posedge clk); #1;

        issue(0, SUB, 32'd10, 32'd4, 32'd6, 2'b10, 1'b0, 1, 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
